// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, PC increment, reset PC default and
// the fetch FSM state type.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_HOLD,
    FS_FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, holds the fetched word for
// decode. Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            pc_source,
  input  logic [XLEN-1:0] pc_target,
  output logic            fetch_misaligned
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] redirect_pc;

  assign imem_addr   = pc;
  // Low target bits are dropped so every redirect lands on a word boundary.
  assign redirect_pc = pc_target & ~32'h3;

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    case (state)
      FS_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_next = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_rsp_valid) state_next = FS_HOLD;
      end
      FS_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_source && (pc_target[1:0] != 2'b00)) begin
            state_next = FS_FAULT;
          end else
`endif
          begin
            state_next = FS_REQ;
            pc_next    = pc_source ? redirect_pc : pc + PC_INC;
          end
        end
      end
      FS_FAULT: state_next = FS_FAULT;
      default:  state_next = FS_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FS_REQ;
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FS_WAIT && imem_rsp_valid) begin
        instr    <= imem_rsp_data;
        instr_pc <= pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // FAULT is only left through reset, so the state itself is the sticky flag.
  assign fetch_misaligned = (state == FS_FAULT);
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_addr  output  32  fetch address (current PC).
REQ-007 imem_rsp_valid  input  1  response data valid.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instruction presented to decode/control.
REQ-010 instr_ready  input  1  decode consumes instruction this cycle.
REQ-011 instr  output  32  held instruction word.
REQ-012 instr_pc  output  32  PC of held instruction.
REQ-013 pc_source  input  1  redirect select from control (1 = take pc_target).
REQ-014 pc_target  input  32  branch/jump target.
REQ-015 fetch_misaligned  output  1  sticky misaligned-target flag.

Function
REQ-016 FSM states REQ, WAIT, HOLD, FAULT; exactly one state active per cycle.
REQ-017 REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready -> WAIT, else stay.
REQ-018 imem_req_valid and imem_addr SHALL stay stable in REQ until accepted.
REQ-019 WAIT: on imem_rsp_valid, capture instr<=imem_rsp_data, instr_pc<=pc -> HOLD.
REQ-020 HOLD: instr_valid=1; instr and instr_pc SHALL stay stable until instr_valid&&instr_ready.
REQ-021 On that handshake: pc<=pc_source ? pc_target : pc+4, -> REQ.
REQ-022 pc_source/pc_target SHALL be ignored on every cycle without handshake.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Exactly one request outstanding; imem_rsp_valid outside WAIT SHALL be ignored.
REQ-025 Best-case latency: request accepted cycle N, response N+1, instr_valid N+2; handshake N+2 -> next request N+3.
REQ-026 instr_valid SHALL be 0 in REQ, WAIT and FAULT.

Reset
REQ-027 On rst: pc=RESET_PC, state=REQ, instr=0, instr_pc=0, instr_valid=0, fetch_misaligned=0; imem_req_valid=1 first cycle after rst deasserts.
REQ-028 rst in any state (incl. WAIT with response pending) SHALL abort; late response lands in REQ and is dropped.
REQ-029 rst SHALL take priority over every simultaneous event.

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with pc_target[1:0]!=2'b00 -> FAULT, fetch_misaligned=1, no further requests until rst.
REQ-031 Macro undefined: pc_target[1:0] forced to 2'b00 on redirect; FAULT unreachable; fetch_misaligned tied 0.

Structure
REQ-032 Package cpu_pkg SHALL hold fetch_state_e enum, XLEN=32, PC_INC=4, DEFAULT_RESET_PC.
REQ-033 No sub-module; PC register, FSM and instruction holding register inline.

Verification
REQ-034 Reset, memory always ready, rsp 1 cycle later -> addrs 0x0,0x4,0x8 fetched; instr_valid cycles 2,5,8 after reset.
REQ-035 instr_ready held 0 for 5 cycles in HOLD -> instr/instr_pc unchanged, no new imem_req_valid.
REQ-036 Handshake with pc_source=1, pc_target=0x100 -> next imem_addr=0x100; pc_source=1 without handshake -> ignored.
REQ-037 pc=0xFFFF_FFFC, handshake, pc_source=0 -> next imem_addr=0x0.
REQ-038 rst in WAIT, rsp_valid one cycle later -> response dropped, imem_addr=RESET_PC, instr_valid=0.
REQ-039 pc_target=0x102 redirect -> macro on: fetch_misaligned=1, requests stop; macro off: next imem_addr=0x100.
